// File: rtl/dualmem_portb_arb.sv
// Port-B arbiter/sequencer for the widening dual-port buffer RAM.
// Two requesters share one synchronous-read port under round-robin arbitration
// with an optional lock. Each requester has one outstanding access, and its
// registered response can be backpressured.
module dualmem_portb_arb #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WE_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [WE_W-1:0]   we0,
  input  logic [WE_W-1:0]   we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ready0,
  output logic              ready1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              rready0,
  input  logic              rready1,
  output logic              mem_en,
  output logic [WE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_HOLD   = 2'd2
  } rsp_state_t;

  rsp_state_t st0_q, st0_d, st1_q, st1_d;
  logic       last_grant_q, lock_held_q, owner_q;
  logic       is_wr0_q, is_wr1_q;
  logic       elig0, elig1, owner_elig;
  logic       grant0, grant1;

  // Eligibility and grant: the lock owner wins ties, otherwise the requester not granted last
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    elig0      = !rst && req0 && (st0_q == ST_IDLE);
    elig1      = !rst && req1 && (st1_q == ST_IDLE);
    owner_elig = owner_q ? elig1 : elig0;
    if (elig0 && elig1) begin
      if (lock_held_q) begin
        grant0 = !owner_q;
        grant1 = owner_q;
      end else begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  // RAM port mux; the address and data default to requester 0 when idle
  always_comb begin
    ready0   = grant0;
    ready1   = grant1;
    mem_en   = grant0 || grant1;
    mem_we   = '0;
    mem_addr = addr0;
    mem_din  = wdata0;
    if (grant1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end else if (grant0) begin
      mem_we = we0;
    end
  end

  // Response FSM next state for both requesters
  always_comb begin
    st0_d = st0_q;
    st1_d = st1_q;
    case (st0_q)
      ST_IDLE:   if (grant0) st0_d = ST_ISSUED;
      ST_ISSUED: st0_d = ST_HOLD;
      ST_HOLD:   if (rready0) st0_d = ST_IDLE;
      default:   st0_d = ST_IDLE;
    endcase
    case (st1_q)
      ST_IDLE:   if (grant1) st1_d = ST_ISSUED;
      ST_ISSUED: st1_d = ST_HOLD;
      ST_HOLD:   if (rready1) st1_d = ST_IDLE;
      default:   st1_d = ST_IDLE;
    endcase
  end

  // Arbitration history, lock tracking and per-requester write flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      lock_held_q  <= 1'b0;
      owner_q      <= 1'b0;
      is_wr0_q     <= 1'b0;
      is_wr1_q     <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        last_grant_q <= grant1;
        owner_q      <= grant1;
        lock_held_q  <= grant1 ? lock1 : lock0;
      end else if (lock_held_q && !owner_elig) begin
        lock_held_q <= 1'b0;
      end
      if (grant0) is_wr0_q <= |we0;
      if (grant1) is_wr1_q <= |we1;
    end
  end

  // Response state and registered response; read data is captured in ISSUED
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st0_q   <= ST_IDLE;
      st1_q   <= ST_IDLE;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      st0_q   <= st0_d;
      st1_q   <= st1_d;
      rvalid0 <= (st0_d == ST_HOLD);
      rvalid1 <= (st1_d == ST_HOLD);
      if (st0_q == ST_ISSUED) rdata0 <= is_wr0_q ? '0 : mem_dout;
      if (st1_q == ST_ISSUED) rdata1 <= is_wr1_q ? '0 : mem_dout;
    end
  end

endmodule

// File: tb/tb_dualmem_portb_arb.sv
// Directed bench for dualmem_portb_arb with a behavioural port-B RAM.
module tb_dualmem_portb_arb;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned WE_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, lock0, lock1;
  logic [WE_W-1:0]   we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ready0, ready1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              rready0, rready1;
  logic              mem_en;
  logic [WE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_wr;

  always #5 clk = ~clk;

  dualmem_portb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .rready0(rready0), .rready1(rready1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Write-first RAM: a write's merged word also appears on mem_dout
  always_comb begin
    ram_wr = ram[mem_addr];
    if (mem_we[0]) ram_wr[31:0]  = mem_din[31:0];
    if (mem_we[1]) ram_wr[63:32] = mem_din[63:32];
  end

  always @(posedge clk) begin
    if (mem_en) begin
      ram[mem_addr] <= ram_wr;
      mem_dout      <= ram_wr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    we0 = '0; we1 = '0; rready0 = 1'b1; rready1 = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    ram[5] = 64'h1122334455667788;
    mem_dout = '0;
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; lock0 = 1'b0; lock1 = 1'b0;
    we0 = '0; we1 = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rready0 = 1'b0; rready1 = 1'b0;
    #1 rst = 1'b1;
    #2;
    // Reset state with both requests raised
    check("rst_ready0", 64'(ready0), 64'd0);
    check("rst_ready1", 64'(ready1), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_rvalid0", 64'(rvalid0), 64'd0);
    check("rst_rvalid1", 64'(rvalid1), 64'd0);
    check("rst_rdata0", rdata0, 64'd0);
    tick();
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

    // Single read of word 0x005
    tick();
    req0 = 1'b1; we0 = 2'b00; addr0 = 11'h005;
    #3;
    check("rd_ready0", 64'(ready0), 64'd1);
    check("rd_mem_en", 64'(mem_en), 64'd1);
    check("rd_mem_addr", 64'(mem_addr), 64'h005);
    check("rd_mem_we", 64'(mem_we), 64'd0);
    tick();
    req0 = 1'b0;
    #3;
    check("rd_issued_ready0", 64'(ready0), 64'd0);
    check("rd_issued_rvalid0", 64'(rvalid0), 64'd0);
    tick();
    #3;
    check("rd_rvalid0", 64'(rvalid0), 64'd1);
    check("rd_rdata0", rdata0, 64'h1122334455667788);
    tick();
    rready0 = 1'b1;
    #3;
    check("rd_hold_rvalid0", 64'(rvalid0), 64'd1);
    check("rd_hold_rdata0", rdata0, 64'h1122334455667788);
    tick();
    rready0 = 1'b0;
    #3;
    check("rd_done_rvalid0", 64'(rvalid0), 64'd0);
    idle(3);

    // Simultaneous requests alternate, first tie to requester 0
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 11'h020; addr1 = 11'h030;
    rready0 = 1'b1; rready1 = 1'b1;
    #3;
    check("rr_c0_ready0", 64'(ready0), 64'd1);
    check("rr_c0_ready1", 64'(ready1), 64'd0);
    check("rr_c0_addr", 64'(mem_addr), 64'h020);
    tick();
    #3;
    check("rr_c1_ready1", 64'(ready1), 64'd1);
    check("rr_c1_ready0", 64'(ready0), 64'd0);
    check("rr_c1_addr", 64'(mem_addr), 64'h030);
    check("rr_c1_mem_en", 64'(mem_en), 64'd1);
    tick();
    #3;
    check("rr_c2_mem_en", 64'(mem_en), 64'd0);
    check("rr_c2_rvalid0", 64'(rvalid0), 64'd1);
    tick();
    #3;
    check("rr_c3_ready0", 64'(ready0), 64'd1);
    tick();
    #3;
    check("rr_c4_ready1", 64'(ready1), 64'd1);
    idle(4);

    // Lock on requester 0
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; addr0 = 11'h040; addr1 = 11'h050;
    rready0 = 1'b1; rready1 = 1'b1;
    #3;
    check("lk_c0_ready0", 64'(ready0), 64'd1);
    check("lk_c0_ready1", 64'(ready1), 64'd0);
    tick();
    #3;
    check("lk_c1_ready1", 64'(ready1), 64'd1);
    check("lk_c1_ready0", 64'(ready0), 64'd0);
    tick();
    #3;
    check("lk_c2_mem_en", 64'(mem_en), 64'd0);
    tick();
    #3;
    check("lk_c3_ready0", 64'(ready0), 64'd1);
    check("lk_c3_ready1", 64'(ready1), 64'd0);
    tick();
    lock0 = 1'b0;
    #3;
    check("lk_c4_ready1", 64'(ready1), 64'd1);
    idle(4);

    // Backpressure on requester 1
    tick();
    req1 = 1'b1; we1 = 2'b00; addr1 = 11'h005; rready1 = 1'b0;
    #3;
    check("bp_c0_ready1", 64'(ready1), 64'd1);
    check("bp_c0_addr", 64'(mem_addr), 64'h005);
    tick();
    #3;
    check("bp_c1_ready1", 64'(ready1), 64'd0);
    check("bp_c1_rvalid1", 64'(rvalid1), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      #3;
      check("bp_stall_rvalid1", 64'(rvalid1), 64'd1);
      check("bp_stall_rdata1", rdata1, 64'h1122334455667788);
      check("bp_stall_ready1", 64'(ready1), 64'd0);
    end
    tick();
    rready1 = 1'b1;
    #3;
    check("bp_hs_rvalid1", 64'(rvalid1), 64'd1);
    check("bp_hs_ready1", 64'(ready1), 64'd0);
    tick();
    #3;
    check("bp_reacc_ready1", 64'(ready1), 64'd1);
    check("bp_reacc_rvalid1", 64'(rvalid1), 64'd0);
    tick();
    req1 = 1'b0;
    idle(4);

    // Lane write then read of word 0x010
    tick();
    req0 = 1'b1; we0 = 2'b01; addr0 = 11'h010; wdata0 = 64'hAAAABBBBCCCCDDDD; rready0 = 1'b1;
    #3;
    check("wr_ready0", 64'(ready0), 64'd1);
    check("wr_mem_we", 64'(mem_we), 64'd1);
    check("wr_mem_din", mem_din, 64'hAAAABBBBCCCCDDDD);
    tick();
    we0 = 2'b00;
    #3;
    check("wr_issued_ready0", 64'(ready0), 64'd0);
    tick();
    #3;
    check("wr_rvalid0", 64'(rvalid0), 64'd1);
    check("wr_rdata0", rdata0, 64'd0);
    tick();
    #3;
    check("wr_rd_ready0", 64'(ready0), 64'd1);
    check("wr_rd_addr", 64'(mem_addr), 64'h010);
    check("wr_rd_mem_we", 64'(mem_we), 64'd0);
    tick();
    req0 = 1'b0;
    tick();
    #3;
    check("wr_rd_rvalid0", 64'(rvalid0), 64'd1);
    check("wr_rd_rdata0", rdata0, 64'h00000000CCCCDDDD);
    idle(3);

    // Reset while requester 0 is in ISSUED
    tick();
    req0 = 1'b1; we0 = 2'b00; addr0 = 11'h005;
    #3;
    check("mr_accept_ready0", 64'(ready0), 64'd1);
    tick();
    req1 = 1'b1; rst = 1'b1;
    #3;
    check("mr_mem_en", 64'(mem_en), 64'd0);
    check("mr_ready0", 64'(ready0), 64'd0);
    check("mr_ready1", 64'(ready1), 64'd0);
    check("mr_rvalid0", 64'(rvalid0), 64'd0);
    check("mr_rdata0", rdata0, 64'd0);
    tick();
    #3;
    check("mr_rst2_rvalid0", 64'(rvalid0), 64'd0);
    tick();
    rst = 1'b0;
    #3;
    check("mr_tie_ready0", 64'(ready0), 64'd1);
    check("mr_tie_ready1", 64'(ready1), 64'd0);
    tick();
    #3;
    check("mr_next_ready1", 64'(ready1), 64'd1);
    check("mr_next_rvalid0", 64'(rvalid0), 64'd0);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
